// File: rtl/io_defs.sv
// Shared IO definitions for the memory-mapped board peripherals.
// Holds the register addresses and the button debounce state encoding.
package io_defs;

    localparam int IO_WIDTH = 16;

    localparam logic [1:0] SW_ADDR_DATA   = 2'b00;
    localparam logic [1:0] SW_ADDR_STATUS = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces the confirm button.
// Emits a single-cycle registered press pulse per accepted press.
module btn_debounce
    import io_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      button,
    output logic      btn_s,
    output logic      press,
    output db_state_t state
);

    localparam logic [CNT_WIDTH-1:0] CNT_PRE = CNT_WIDTH'(DEBOUNCE_CYCLES - 2);

    logic                 btn_meta;
    logic [1:0]           fill;
    logic                 armed;
    logic [CNT_WIDTH-1:0] cnt;

    // A button still held across reset must be released before it can count
    // as a press: arming waits for the synchronizer to flush and show a 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            fill     <= 2'b00;
            armed    <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            btn_meta <= button;
            btn_s    <= btn_meta;
            fill     <= {fill[0], 1'b1};
            press    <= 1'b0;
            if (fill[1] && !btn_s) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (btn_s && armed) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_PRE) begin
                            state <= HELD;
                            press <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (btn_s) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_PRE) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/switch_in.sv
// Press-qualified switch input port: latches a switch snapshot on each
// debounced button press and serves DATA/STATUS reads to MemOrIO.
module switch_in
    import io_defs::*;
#(
    parameter int DATA_WIDTH      = IO_WIDTH,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] switches,
    input  logic                  confirm_button,
    input  logic                  ior,
    input  logic                  switchctrl,
    input  logic [1:0]            swaddr,
    output logic [DATA_WIDTH-1:0] ioread_data,
    output logic                  data_valid,
    output logic                  overrun,
    output logic [1:0]            debug_state
);

    logic [DATA_WIDTH-1:0] sw_meta;
    logic [DATA_WIDTH-1:0] sw_s;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  btn_s;
    logic                  press;
    db_state_t             db_state;
    logic                  data_read;
    logic                  status_read;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_db (
        .clock (clock),
        .reset (reset),
        .button(confirm_button),
        .btn_s (btn_s),
        .press (press),
        .state (db_state)
    );

    assign debug_state = db_state;
    assign data_read   = ior && switchctrl && (swaddr == SW_ADDR_DATA);
    assign status_read = ior && switchctrl && (swaddr == SW_ADDR_STATUS);

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta    <= '0;
            sw_s       <= '0;
            data_reg   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sw_meta <= switches;
            sw_s    <= sw_meta;
            // A new press beats a same-cycle read clear of either flag.
            if (press) begin
                data_reg   <= sw_s;
                data_valid <= 1'b1;
            end else if (data_read) begin
                data_valid <= 1'b0;
            end
            if (press && data_valid && !data_read) begin
                overrun <= 1'b1;
            end else if (status_read) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        ioread_data = '0;
        if (data_read) begin
            ioread_data = data_reg;
        end else if (status_read) begin
            ioread_data = {{(DATA_WIDTH-2){1'b0}}, overrun, data_valid};
        end
    end

endmodule

// File: tb/tb_switch_in.sv
// Directed bench for switch_in with a short debounce window.
module tb_switch_in;

    localparam int W  = 16;
    localparam int DC = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  switches = '0;
    logic          confirm_button = 1'b0;
    logic          ior = 1'b0;
    logic          switchctrl = 1'b0;
    logic [1:0]    swaddr = 2'b00;
    logic [W-1:0]  ioread_data;
    logic          data_valid;
    logic          overrun;
    logic [1:0]    debug_state;

    int checks   = 0;
    int failures = 0;
    int press_cnt = 0;

    switch_in #(
        .DATA_WIDTH     (W),
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH      (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .switches      (switches),
        .confirm_button(confirm_button),
        .ior           (ior),
        .switchctrl    (switchctrl),
        .swaddr        (swaddr),
        .ioread_data   (ioread_data),
        .data_valid    (data_valid),
        .overrun       (overrun),
        .debug_state   (debug_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && dut.press) press_cnt <= press_cnt + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_read(input logic en, input logic [1:0] addr);
        ior        = en;
        switchctrl = en;
        swaddr     = addr;
    endtask

    // Hold the button long enough for one press, then release and settle.
    task automatic press_button(input logic [W-1:0] sw);
        switches = sw;
        cycles(3);
        confirm_button = 1'b1;
        cycles(8);
        confirm_button = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(1);
        checks++;
        if (ioread_data !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", ioread_data); end
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++;
        if (debug_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", debug_state); end
        set_read(1'b1, 2'b10);
        #1;
        checks++;
        if (ioread_data !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=0000", ioread_data); end
        cycles(1);
        set_read(1'b0, 2'b00);
        cycles(4);
    endtask

    task automatic test_single_press;
        int p0;
        p0 = press_cnt;
        switches = 16'hA5C3;
        cycles(3);
        confirm_button = 1'b1;
        cycles(6);
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", data_valid); end
        cycles(1);
        checks++;
        if (data_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", data_valid); end
        cycles(3);
        confirm_button = 1'b0;
        cycles(10);
        checks++;
        if (press_cnt - p0 !== 1) begin failures++; $display("FAIL single_press_count got=%0d exp=1", press_cnt - p0); end
        set_read(1'b1, 2'b00);
        #1;
        checks++;
        if (ioread_data !== 16'hA5C3) begin failures++; $display("FAIL single_data got=%h exp=a5c3", ioread_data); end
        cycles(1);
        set_read(1'b1, 2'b10);
        #1;
        checks++;
        if (ioread_data !== 16'h0000) begin failures++; $display("FAIL single_status got=%h exp=0000", ioread_data); end
        cycles(1);
        set_read(1'b0, 2'b00);
        cycles(2);
    endtask

    task automatic test_glitch;
        int p0;
        p0 = press_cnt;
        switches = 16'h5A5A;
        for (int len = 1; len <= 3; len++) begin
            confirm_button = 1'b1;
            cycles(len);
            confirm_button = 1'b0;
            cycles(10);
        end
        checks++;
        if (press_cnt - p0 !== 0) begin failures++; $display("FAIL glitch_press got=%0d exp=0", press_cnt - p0); end
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", data_valid); end
    endtask

    task automatic test_overrun;
        press_button(16'h0001);
        press_button(16'h0002);
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
        set_read(1'b1, 2'b00);
        #1;
        checks++;
        if (ioread_data !== 16'h0002) begin failures++; $display("FAIL overrun_data got=%h exp=0002", ioread_data); end
        cycles(1);
        set_read(1'b1, 2'b10);
        #1;
        checks++;
        if (ioread_data !== 16'h0002) begin failures++; $display("FAIL overrun_status1 got=%h exp=0002", ioread_data); end
        cycles(1);
        #1;
        checks++;
        if (ioread_data !== 16'h0000) begin failures++; $display("FAIL overrun_status2 got=%h exp=0000", ioread_data); end
        cycles(1);
        set_read(1'b0, 2'b00);
        // Unselected and unmapped reads return zero and leave flags alone.
        press_button(16'h00F0);
        set_read(1'b1, 2'b01);
        #1;
        checks++;
        if (ioread_data !== 16'h0000) begin failures++; $display("FAIL unmapped_rdata got=%h exp=0000", ioread_data); end
        cycles(1);
        ior = 1'b1; switchctrl = 1'b0; swaddr = 2'b00;
        #1;
        checks++;
        if (ioread_data !== 16'h0000) begin failures++; $display("FAIL unselected_rdata got=%h exp=0000", ioread_data); end
        cycles(1);
        set_read(1'b0, 2'b00);
        checks++;
        if (data_valid !== 1'b1) begin failures++; $display("FAIL no_side_effect got=%b exp=1", data_valid); end
        set_read(1'b1, 2'b00);
        cycles(1);
        set_read(1'b0, 2'b00);
    endtask

    task automatic test_read_in_press_cycle;
        press_button(16'h1234);
        switches = 16'h5678;
        cycles(3);
        confirm_button = 1'b1;
        cycles(6);
        set_read(1'b1, 2'b00);
        #1;
        checks++;
        if (ioread_data !== 16'h1234) begin failures++; $display("FAIL press_cycle_old_data got=%h exp=1234", ioread_data); end
        cycles(1);
        set_read(1'b0, 2'b00);
        checks++;
        if (data_valid !== 1'b1) begin failures++; $display("FAIL press_cycle_valid got=%b exp=1", data_valid); end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL press_cycle_overrun got=%b exp=0", overrun); end
        set_read(1'b1, 2'b00);
        #1;
        checks++;
        if (ioread_data !== 16'h5678) begin failures++; $display("FAIL press_cycle_new_data got=%h exp=5678", ioread_data); end
        cycles(1);
        set_read(1'b0, 2'b00);
        cycles(2);
        confirm_button = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset_mid_debounce;
        int p0;
        switches = 16'hBEEF;
        cycles(3);
        confirm_button = 1'b1;
        cycles(4);
        checks++;
        if (debug_state !== 2'd1) begin failures++; $display("FAIL mid_db_state got=%0d exp=1", debug_state); end
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        p0 = press_cnt;
        cycles(12);
        checks++;
        if (press_cnt - p0 !== 0) begin failures++; $display("FAIL mid_db_press got=%0d exp=0", press_cnt - p0); end
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL mid_db_valid got=%b exp=0", data_valid); end
        checks++;
        if (debug_state !== 2'd0) begin failures++; $display("FAIL mid_db_idle got=%0d exp=0", debug_state); end
        confirm_button = 1'b0;
        cycles(8);
        confirm_button = 1'b1;
        cycles(8);
        confirm_button = 1'b0;
        cycles(10);
        checks++;
        if (press_cnt - p0 !== 1) begin failures++; $display("FAIL repress_count got=%0d exp=1", press_cnt - p0); end
        set_read(1'b1, 2'b00);
        #1;
        checks++;
        if (ioread_data !== 16'hBEEF) begin failures++; $display("FAIL repress_data got=%h exp=beef", ioread_data); end
        cycles(1);
        set_read(1'b0, 2'b00);
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_glitch;
        test_overrun;
        test_read_in_press_cycle;
        test_reset_mid_debounce;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_in.md
# switch_in

Buffered input peripheral that is the read-side counterpart of the LED output port. It synchronizes and debounces `confirm_button`, and on each debounced press latches a snapshot of the 16 board switches into a data register. It sets a valid flag and presents the data to `MemOrIO` through the same `ior`/`switchctrl` select that the CPU's IO-read path uses. It sits between the board pins and `MemOrIO`, replacing the purely combinational switch read with a press-qualified, consume-once value.

## Interface
- `DATA_WIDTH`, 16, width of switch bus and `ioread_data`.
- `DEBOUNCE_CYCLES`, 200000, consecutive stable synchronized samples required to accept a button level change; minimum 2.
- `CNT_WIDTH`, 18, debounce counter width; must satisfy `2^CNT_WIDTH > DEBOUNCE_CYCLES`.

- `clock` in 1: single clock (`clk1` domain). One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `switches` in `DATA_WIDTH`: raw asynchronous switch pins.
- `confirm_button` in 1: raw asynchronous button, high = pressed.
- `ior` in 1: IO read from Controller.
- `switchctrl` in 1: switch device selected, from `MemOrIO`.
- `swaddr` in 2: register select. 2'b00 selects DATA; 2'b10 selects STATUS.
- `ioread_data` out `DATA_WIDTH`: read data to `MemOrIO`.
- `data_valid` out 1: an unread snapshot is held.
- `overrun` out 1: a snapshot was overwritten before it was read.

## Operation
- `switches` and `confirm_button` each pass through a 2-FF synchronizer. All logic uses the synchronized values `sw_s` and `btn_s`.
- The debounce FSM has four states: IDLE, DB_PRESS, HELD, DB_RELEASE.
  - IDLE: if `btn_s`=1, go to DB_PRESS and clear the counter.
  - DB_PRESS: if `btn_s`=0, return to IDLE. Otherwise increment the counter. When the counter reaches `DEBOUNCE_CYCLES-1`, go to HELD and pulse `press`.
  - HELD: if `btn_s`=0, go to DB_RELEASE and clear the counter.
  - DB_RELEASE: if `btn_s`=1, return to HELD. Otherwise count; at `DEBOUNCE_CYCLES-1`, go to IDLE.
- Exactly one `press` pulse is produced per debounced press. Holding the button produces no repeats.
- On `press`:
  - `data_reg` <= `sw_s`.
  - `data_valid` <= 1.
  - If `data_valid` was already 1 and no DATA read occurs in the same cycle, `overrun` <= 1.
- DATA read is `ior && switchctrl && swaddr==2'b00`.
  - `ioread_data` = `data_reg`, combinationally, in the same cycle.
  - At the next edge, `data_valid` <= 0, unless `press` occurs in that cycle. Press wins: `data_valid` stays 1 with the new data, and `overrun` is not set.
- STATUS read is `ior && switchctrl && swaddr==2'b10`.
  - `ioread_data` = {14'b0, `overrun`, `data_valid`}.
  - At the next edge, `overrun` <= 0. A `press`-driven overrun set in the same cycle wins.
- Any other `swaddr`, or when not selected: `ioread_data` = 0. Reads have no side effects in that case.
- A DATA read while `data_valid`=0 returns the stale `data_reg` and causes no error.

## Timing
- Reset values:
  - `ioread_data` = 0 (no selection active).
  - `data_valid` = 0, `overrun` = 0, `data_reg` = 0.
  - FSM in IDLE, counter 0, synchronizers 0.
- Reset asserted mid-debounce or mid-read abandons all state. There is no `press` in or after the reset cycle.
- Press latency: raw button high sampled at edge N; `btn_s`=1 after edge N+2; `press` is high in the cycle after edge N+1+DEBOUNCE_CYCLES; `data_valid`=1 after edge N+2+DEBOUNCE_CYCLES.
- The latched data is the `sw_s` value present in the `press` cycle, i.e. the pins from 2 cycles earlier.
- Read clear takes effect one edge after the read cycle. A back-to-back second read of DATA sees `data_valid`=0 in STATUS.
- Glitch rejection: any `btn_s` pulse shorter than `DEBOUNCE_CYCLES` cycles produces no `press`.
- The counter never wraps; it is held from the terminal count until the next state change.

## Structure
- Shared package `io_defs`:
  - `SW_ADDR_DATA` = 2'b00, `SW_ADDR_STATUS` = 2'b10.
  - Debounce state encoding (IDLE/DB_PRESS/HELD/DB_RELEASE).
  - `IO_WIDTH` reused for `DATA_WIDTH`.
- Sub-module `btn_debounce`: synchronizer, FSM and counter; outputs `btn_s` and the one-cycle `press`. The top handles the switch synchronizer, data/valid/overrun registers and the read mux.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
- Reset, then idle: `ioread_data`=0, `data_valid`=0, `overrun`=0; a STATUS read returns 16'h0000.
- `switches`=16'hA5C3, button held 10 cycles: exactly one `press`; `data_valid`=1 after edge N+6; a DATA read returns 16'hA5C3; a STATUS read on the next cycle returns 16'h0000.
- Button pulses of 1, 2 and 3 cycles: no `press`; `data_valid` stays 0.
- Two debounced presses with switches 16'h0001 then 16'h0002 and no read between: `overrun`=1; DATA read returns 16'h0002; a STATUS read returns 16'h0002 (overrun bit) and the next STATUS read returns 16'h0000.
- DATA read issued in the exact `press` cycle: the read returns the old data, `data_valid` stays 1, `overrun` stays 0.
- Reset asserted 2 cycles into DB_PRESS with the button still held: no `press` after reset; a new press is recognized only after the button is released and pressed again.
